// File: rtl/ex_div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU in EX, with stall request and flush handling.
// Optional macro DIV_EARLY_OUT_EN: finish at once when |divisor| > |dividend|.
module ex_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start_i,
    input  logic             div_signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             stall_ex_i,
    input  logic             flush_i,
    output logic             streq_ex_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             res_valid_o
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic neg);
        mag_w = neg ? neg_w(v) : v;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic             qsign_r;
    logic             rsign_r;

    logic             sa_s;
    logic             sb_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dsr_mag_s;
    logic             zero_div_s;
    logic             early_s;
    logic             start_s;
    logic             streq_s;

    logic [WIDTH:0]   shift_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;
    logic [WIDTH-1:0] quot_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    assign sa_s       = div_signed_i & dividend_i[WIDTH-1];
    assign sb_s       = div_signed_i & divisor_i[WIDTH-1];
    assign dvd_mag_s  = mag_w(dividend_i, sa_s);
    assign dsr_mag_s  = mag_w(divisor_i, sb_s);
    assign zero_div_s = (divisor_i == ZERO_W);
    assign start_s    = div_start_i & ~flush_i;

`ifdef DIV_EARLY_OUT_EN
    assign early_s = ~zero_div_s & (dsr_mag_s > dvd_mag_s);
`else
    assign early_s = 1'b0;
`endif

    // The shifted partial remainder needs one extra bit; after the compare it fits back in WIDTH.
    assign shift_s    = {rem_r, dvd_r[WIDTH-1]};
    assign ge_s       = (shift_s >= {1'b0, dsr_r});
    assign rem_step_s = ge_s ? (shift_s[WIDTH-1:0] - dsr_r) : shift_s[WIDTH-1:0];
    assign quo_step_s = {dvd_r[WIDTH-2:0], ge_s};
    assign quot_fix_s = qsign_r ? neg_w(quo_step_s) : quo_step_s;
    assign rem_fix_s  = rsign_r ? neg_w(rem_step_s) : rem_step_s;

    assign streq_ex_o = streq_s;

    // Next-state and stall-request logic; a flush overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        streq_s     = 1'b0;
        if (flush_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (div_start_i) begin
                        streq_s = 1'b1;
                        if (zero_div_s || early_s) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_BUSY;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    streq_s = 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (!stall_ex_i) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, iteration datapath and registered results.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r       <= CNT_ZERO;
            rem_r       <= ZERO_W;
            dvd_r       <= ZERO_W;
            dsr_r       <= ZERO_W;
            qsign_r     <= 1'b0;
            rsign_r     <= 1'b0;
            quot_o      <= ZERO_W;
            rem_o       <= ZERO_W;
            res_valid_o <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        dvd_r   <= dvd_mag_s;
                        dsr_r   <= dsr_mag_s;
                        rem_r   <= ZERO_W;
                        cnt_r   <= CNT_ZERO;
                        qsign_r <= sa_s ^ sb_s;
                        rsign_r <= sa_s;
                        // Zero divisor and early-out bypass the iterations and the sign fix-up.
                        if (zero_div_s) begin
                            quot_o      <= ONES_W;
                            rem_o       <= dividend_i;
                            res_valid_o <= 1'b1;
                        end else if (early_s) begin
                            quot_o      <= ZERO_W;
                            rem_o       <= dividend_i;
                            res_valid_o <= 1'b1;
                        end else begin
                            res_valid_o <= 1'b0;
                        end
                    end else begin
                        res_valid_o <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (!flush_i) begin
                        rem_r <= rem_step_s;
                        dvd_r <= quo_step_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            quot_o      <= quot_fix_s;
                            rem_o       <= rem_fix_s;
                            res_valid_o <= 1'b1;
                        end else begin
                            res_valid_o <= 1'b0;
                        end
                    end else begin
                        res_valid_o <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (flush_i || !stall_ex_i) begin
                        res_valid_o <= 1'b0;
                    end else begin
                        res_valid_o <= 1'b1;
                    end
                end
                default: begin
                    res_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: scoreboard of expected quotient/remainder checked on res_valid_o.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_start_i;
    logic        div_signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        stall_ex_i;
    logic        flush_i;
    logic        streq_ex_o;
    logic [31:0] quot_o;
    logic [31:0] rem_o;
    logic        res_valid_o;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    ex_div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .div_start_i  (div_start_i),
        .div_signed_i (div_signed_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .stall_ex_i   (stall_ex_i),
        .flush_i      (flush_i),
        .streq_ex_o   (streq_ex_o),
        .quot_o       (quot_o),
        .rem_o        (rem_o),
        .res_valid_o  (res_valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else if (sgn) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    function automatic int exp_req(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (sgn && a[31]) ? (32'd0 - a) : a;
        mb = (sgn && b[31]) ? (32'd0 - b) : b;
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (mb > ma) return 1;
`else
        if (mb == 32'd0 && ma == 32'd0) return 1;
`endif
        return 33;
    endfunction

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int stall_n, input string tag);
        exp_t e;
        int   n;
        bit   got;
        @(posedge clk); #1;
        div_start_i  = 1'b1;
        div_signed_i = sgn;
        dividend_i   = a;
        divisor_i    = b;
        stall_ex_i   = (stall_n > 0);
        sb_q.push_back(model(sgn, a, b));
        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (res_valid_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (streq_ex_o === 1'b1) n++;
        end
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_reqcyc"}, 32'(n), 32'(exp_req(sgn, a, b)));
        e = sb_q.pop_front();
        chk({tag, "_quot"}, quot_o, e.q);
        chk({tag, "_rem"}, rem_o, e.r);
        chk({tag, "_done_req"}, 32'(streq_ex_o), 32'd0);
        for (int s = 1; s <= stall_n; s++) begin
            @(posedge clk); #1;
            if (s == stall_n) stall_ex_i = 1'b0;
            @(negedge clk);
            chk({tag, "_stall_valid"}, 32'(res_valid_o), 32'd1);
            chk({tag, "_stall_quot"}, quot_o, e.q);
            chk({tag, "_stall_req"}, 32'(streq_ex_o), 32'd0);
        end
        @(posedge clk); #1;
        div_start_i = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_valid"}, 32'(res_valid_o), 32'd0);
        chk({tag, "_idle_req"}, 32'(streq_ex_o), 32'd0);
    endtask

    initial begin
        int seen;
        resetn       = 1'b0;
        div_start_i  = 1'b0;
        div_signed_i = 1'b0;
        dividend_i   = 32'd0;
        divisor_i    = 32'd0;
        stall_ex_i   = 1'b0;
        flush_i      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_quot", quot_o, 32'd0);
        chk("rst_rem", rem_o, 32'd0);
        chk("rst_valid", 32'(res_valid_o), 32'd0);
        chk("rst_req", 32'(streq_ex_o), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div_m7_2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_div(1'b0, 32'h0000_1234, 32'd0, 0, "divu_by0");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 0, "div_m7_by0");
        run_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0, "div_7_m2");

        // Flush during BUSY cycle 10: request drops, nothing is ever reported.
        @(posedge clk); #1;
        div_start_i  = 1'b1;
        div_signed_i = 1'b0;
        dividend_i   = 32'd1000;
        divisor_i    = 32'd3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("flush_pre_req", 32'(streq_ex_o), 32'd1);
        @(posedge clk); #1;
        flush_i     = 1'b1;
        div_start_i = 1'b0;
        @(negedge clk);
        chk("flush_req", 32'(streq_ex_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_idle_req", 32'(streq_ex_o), 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (res_valid_o !== 1'b0) seen++;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        run_div(1'b0, 32'd9, 32'd3, 0, "divu_9_3");

        run_div(1'b0, 32'd50, 32'd5, 3, "divu_50_5_stall");
        run_div(1'b0, 32'd5, 32'd9, 0, "divu_5_9");
        run_div(1'b1, 32'hFFFF_FFFB, 32'd9, 0, "div_m5_9");

        // Asynchronous reset in the middle of an iteration.
        @(posedge clk); #1;
        div_start_i  = 1'b1;
        div_signed_i = 1'b0;
        dividend_i   = 32'd1000;
        divisor_i    = 32'd7;
        repeat (10) @(posedge clk);
        #2;
        resetn      = 1'b0;
        div_start_i = 1'b0;
        #1;
        chk("midrst_quot", quot_o, 32'd0);
        chk("midrst_rem", rem_o, 32'd0);
        chk("midrst_valid", 32'(res_valid_o), 32'd0);
        chk("midrst_req", 32'(streq_ex_o), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (res_valid_o !== 1'b0 || streq_ex_o !== 1'b0) seen++;
        end
        chk("midrst_quiet", 32'(seen), 32'd0);
        run_div(1'b0, 32'd100, 32'd7, 0, "post_rst_divu");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU in the EX stage.
- It is the requester side of the pipeline stall protocol: it raises the EX stall request to the hazard/stall controller while a divide is in flight.
- It consumes the resulting EX stall and flush signals so that it never restarts or completes a squashed instruction.
- Results go to the HI/LO write path.

Parameters:
- WIDTH, 32, operand/result width; iteration counter is $clog2(WIDTH) bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- div_start_i  input  1  DIV/DIVU instruction currently valid in EX; held high while the instruction sits in EX.
- div_signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend_i  input  WIDTH  rs operand; sampled with start.
- divisor_i  input  WIDTH  rt operand; sampled with start.
- stall_ex_i  input  1  EX stage held this cycle (from stall controller).
- flush_i  input  1  EX flush or exception flag; squashes any operation.
- streq_ex_o  output  1  stall request to the stall controller.
- quot_o  output  WIDTH  quotient, for LO.
- rem_o  output  WIDTH  remainder, for HI.
- res_valid_o  output  1  quot_o/rem_o are valid for the instruction in EX.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state IDLE, counter 0, quot_o 0, rem_o 0, res_valid_o 0, streq_ex_o 0.
- streq_ex_o (combinational):
  - = (IDLE & div_start_i & ~flush_i) | (BUSY & ~flush_i).
  - Always 0 in DONE.
  - Forced 0 in any cycle where flush_i is high.
- IDLE:
  - If div_start_i & ~flush_i: latch |dividend| and |divisor| (absolute values only when div_signed_i; else raw), latch quotient sign = sa^sb and remainder sign = sa, clear partial remainder, counter = 0.
  - Next state is BUSY, or DONE directly when divisor == 0.
- BUSY:
  - Restoring radix-2: one quotient bit per cycle, MSB first.
  - Shift {rem, dvd} left 1; if rem >= divisor magnitude, subtract and set the quotient bit.
  - Partial remainder is WIDTH+1 bits to avoid overflow.
  - After the iteration with counter == WIDTH-1: apply sign fix-up (two's-complement negate quotient if qsign, remainder if rsign), register quot_o/rem_o, then go to DONE.
- Latency: streq_ex_o is high for exactly WIDTH+1 cycles (the start cycle plus 32 BUSY cycles); res_valid_o rises on the following cycle.
- DONE:
  - res_valid_o = 1 and results are held stable.
  - Go to IDLE when stall_ex_i == 0, since the instruction advances this cycle.
  - While stall_ex_i == 1 (a later stage is stalling), stay in DONE and do not restart, even though div_start_i remains high.
- Divide by zero: quot_o = all ones, rem_o = raw dividend_i, no sign fix-up; DONE is reached one cycle after start (streq_ex_o high 1 cycle).
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quot_o = 0x80000000, rem_o = 0. This falls out of magnitude arithmetic.
- Flush:
  - flush_i high in any state makes the next state IDLE, clears res_valid_o, and suppresses the request that cycle.
  - Simultaneous flush_i and div_start_i in IDLE: no start.
- A back-to-back divide can only start from IDLE. It is therefore delayed at least one cycle after DONE.
- resetn deasserted mid-BUSY: immediate return to reset values; no partial result is ever exposed.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- When defined: in IDLE at start, if divisor magnitude > dividend magnitude (and divisor != 0), go straight to DONE with quot_o = 0 and rem_o = dividend_i (original signed value). streq_ex_o is high for 1 cycle only.
- When undefined: all nonzero-divisor cases take the full WIDTH iterations.

Test Plan:
- DIVU 100/7 with stall_ex_i = 0 -> streq_ex_o high 33 cycles, then res_valid_o = 1, quot_o = 14, rem_o = 2; returns to IDLE next cycle.
- DIV -7/2 (0xFFFFFFF9 / 0x2) -> quot_o = 0xFFFFFFFD, rem_o = 0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF -> quot_o = 0x80000000, rem_o = 0.
- DIVU 0x1234 / 0 -> streq_ex_o high 1 cycle, quot_o = 0xFFFFFFFF, rem_o = 0x1234.
- DIVU started, flush_i pulsed at BUSY cycle 10 -> streq_ex_o = 0 that cycle, IDLE next cycle, res_valid_o never set. A following DIVU 9/3 then gives quot_o 3, rem_o 0.
- DIVU 50/5 reaching DONE with stall_ex_i held high 3 cycles and div_start_i high -> quot_o stays 10, no restart, streq_ex_o stays 0, IDLE after stall_ex_i drops.
- With DIV_EARLY_OUT_EN: DIVU 5/9 -> streq_ex_o high 1 cycle, quot_o = 0, rem_o = 5. Without the macro -> 33-cycle request, same result.
